// File: rtl/bcd_disp_pkg.sv
// Shared constants for the multiplexed 4-digit common-anode 7-segment display.
// Glyphs are active-low and packed {g,f,e,d,c,b,a}.
package bcd_disp_pkg;

  localparam int NUM_DIGITS = 4;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD nibble to active-low 7-segment glyph decoder.
// Non-decimal nibbles show a dash so corrupt upstream data is visible.
module bcd_to_seg7
  import bcd_disp_pkg::*;
(
  input  logic [3:0] nibble_i,
  input  logic       blank_digit_i,
  output logic [6:0] seg_o
);

  // Glyph lookup; blanking overrides the digit value
  always_comb begin
    seg_o = SEG_DASH;
    if (blank_digit_i) begin
      seg_o = SEG_BLANK;
    end else begin
      case (nibble_i)
        4'd0:    seg_o = SEG_0;
        4'd1:    seg_o = SEG_1;
        4'd2:    seg_o = SEG_2;
        4'd3:    seg_o = SEG_3;
        4'd4:    seg_o = SEG_4;
        4'd5:    seg_o = SEG_5;
        4'd6:    seg_o = SEG_6;
        4'd7:    seg_o = SEG_7;
        4'd8:    seg_o = SEG_8;
        4'd9:    seg_o = SEG_9;
        default: seg_o = SEG_DASH;
      endcase
    end
  end

endmodule

// File: rtl/bcd_scan_7seg.sv
// Round-robin scanner for a 4-digit common-anode display. New values are
// staged in a pending register and only committed at the end of a full
// frame so a refresh never mixes digits from two different values.
module bcd_scan_7seg
  import bcd_disp_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter bit LZ_BLANK    = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [15:0]           bcd_in,
  input  logic                  load,
  input  logic [NUM_DIGITS-1:0] dp_in,
  input  logic                  blank,
  output logic [NUM_DIGITS-1:0] an,
  output logic [6:0]            seg,
  output logic                  dp
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] PRESCALE_LAST = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0]      prescale_q, prescale_d;
  logic [1:0]            digitIdx_q, digitIdx_d;
  logic [15:0]           pendBcd_q, pendBcd_d;
  logic [NUM_DIGITS-1:0] pendDp_q, pendDp_d;
  logic                  pendValid_q, pendValid_d;
  logic [15:0]           shownBcd_q, shownBcd_d;
  logic [NUM_DIGITS-1:0] shownDp_q, shownDp_d;
  logic [NUM_DIGITS-1:0] an_d;
  logic                  dp_d;
  logic [6:0]            segDec;

  logic                  tick;
  logic                  frameEnd;
  logic [3:0]            curNibble;
  logic [NUM_DIGITS-1:0] lzBlank;
  logic                  curBlank;

  assign tick     = (prescale_q == PRESCALE_LAST);
  assign frameEnd = tick && (digitIdx_q == 2'd3);

  // Next-state for scan counters and the pending/shown staging registers;
  // a load coinciding with frame end still lets the older pending value commit
  always_comb begin
    prescale_d  = tick ? '0 : prescale_q + 1'b1;
    digitIdx_d  = tick ? digitIdx_q + 2'd1 : digitIdx_q;
    pendBcd_d   = pendBcd_q;
    pendDp_d    = pendDp_q;
    pendValid_d = pendValid_q;
    shownBcd_d  = shownBcd_q;
    shownDp_d   = shownDp_q;
    if (frameEnd && pendValid_q) begin
      shownBcd_d  = pendBcd_q;
      shownDp_d   = pendDp_q;
      pendValid_d = 1'b0;
    end
    if (load) begin
      pendBcd_d   = bcd_in;
      pendDp_d    = dp_in;
      pendValid_d = 1'b1;
    end
  end

  // Select the nibble being scanned and work out leading-zero suppression
  always_comb begin
    curNibble = shownBcd_q[3:0];
    case (digitIdx_q)
      2'd0: curNibble = shownBcd_q[3:0];
      2'd1: curNibble = shownBcd_q[7:4];
      2'd2: curNibble = shownBcd_q[11:8];
      2'd3: curNibble = shownBcd_q[15:12];
      default: curNibble = shownBcd_q[3:0];
    endcase
    lzBlank    = '0;
    lzBlank[3] = LZ_BLANK && (shownBcd_q[15:12] == 4'd0);
    lzBlank[2] = lzBlank[3] && (shownBcd_q[11:8] == 4'd0);
    lzBlank[1] = lzBlank[2] && (shownBcd_q[7:4] == 4'd0);
    curBlank   = blank || lzBlank[digitIdx_q];
  end

  bcd_to_seg7 u_dec (
    .nibble_i      (curNibble),
    .blank_digit_i (curBlank),
    .seg_o         (segDec)
  );

  // Digit-enable and decimal point for the current scan position
  always_comb begin
    an_d = 4'b1111;
    dp_d = 1'b1;
    if (!curBlank) begin
      an_d = ~(4'b0001 << digitIdx_q);
      dp_d = ~shownDp_q[digitIdx_q];
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      prescale_q  <= '0;
      digitIdx_q  <= 2'd0;
      pendBcd_q   <= 16'h0000;
      pendDp_q    <= '0;
      pendValid_q <= 1'b0;
      shownBcd_q  <= 16'h0000;
      shownDp_q   <= '0;
      an          <= 4'b1111;
      seg         <= SEG_BLANK;
      dp          <= 1'b1;
    end else begin
      prescale_q  <= prescale_d;
      digitIdx_q  <= digitIdx_d;
      pendBcd_q   <= pendBcd_d;
      pendDp_q    <= pendDp_d;
      pendValid_q <= pendValid_d;
      shownBcd_q  <= shownBcd_d;
      shownDp_q   <= shownDp_d;
      an          <= an_d;
      seg         <= segDec;
      dp          <= dp_d;
    end
  end

endmodule

// File: tb/tb_bcd_scan_7seg.sv
// Testbench for bcd_scan_7seg with REFRESH_DIV=4. Expected display states are
// queued per cycle index (cycles counted from reset release) and a monitor
// compares them on the falling edge. A second instance runs with LZ_BLANK=0.
module tb_bcd_scan_7seg;

  typedef struct {
    int         k;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  localparam logic [6:0] G0 = 7'h40, G1 = 7'h79, G2 = 7'h24, G3 = 7'h30;
  localparam logic [6:0] G4 = 7'h19, G5 = 7'h12, G7 = 7'h78, G9 = 7'h10;
  localparam logic [6:0] GDASH = 7'h3F, GOFF = 7'h7F;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] bcd_in;
  logic        load;
  logic [3:0]  dp_in;
  logic        blank;
  logic [3:0]  anA, anB;
  logic [6:0]  segA, segB;
  logic        dpA, dpB;

  int   kCnt = -100;
  int   nChecks = 0;
  int   nFail = 0;
  exp_t qA[$];
  exp_t qB[$];
  exp_t eA, eB;

  bcd_scan_7seg #(.REFRESH_DIV(4), .LZ_BLANK(1'b1)) dutA (
    .clk(clk), .rst(rst), .bcd_in(bcd_in), .load(load), .dp_in(dp_in),
    .blank(blank), .an(anA), .seg(segA), .dp(dpA)
  );

  bcd_scan_7seg #(.REFRESH_DIV(4), .LZ_BLANK(1'b0)) dutB (
    .clk(clk), .rst(rst), .bcd_in(bcd_in), .load(load), .dp_in(dp_in),
    .blank(blank), .an(anB), .seg(segB), .dp(dpB)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Cycle index: -1 during reset, 0 after the first edge with reset low
  always @(posedge clk) kCnt <= rst ? -1 : kCnt + 1;

  task automatic checkOutput(input string tag, input exp_t e, input logic [3:0] an,
                             input logic [6:0] seg, input logic dp);
    nChecks++;
    if (an !== e.an || seg !== e.seg || dp !== e.dp) begin
      nFail++;
      $display("[TB] FAIL %s k=%0d: got an=%b seg=%b dp=%b, expected an=%b seg=%b dp=%b",
               tag, e.k, an, seg, dp, e.an, e.seg, e.dp);
    end
  endtask

  // Monitor: pop every expectation due in the current cycle and compare
  always @(negedge clk) begin
    while (qA.size() > 0 && qA[0].k == kCnt) begin
      eA = qA.pop_front();
      checkOutput("lz_on", eA, anA, segA, dpA);
    end
    while (qB.size() > 0 && qB[0].k == kCnt) begin
      eB = qB.pop_front();
      checkOutput("lz_off", eB, anB, segB, dpB);
    end
  end

  task automatic pushOne(input bit toB, input int k, input logic [3:0] an,
                         input logic [6:0] seg, input logic dp);
    exp_t e;
    e.k = k; e.an = an; e.seg = seg; e.dp = dp;
    if (toB) qB.push_back(e);
    else     qA.push_back(e);
  endtask

  // Queue len cycles starting at k0; glyphs/visibility/dp given per digit
  task automatic pushFrame(input bit toB, input int k0, input int len,
                           input logic [6:0] s0, input logic [6:0] s1,
                           input logic [6:0] s2, input logic [6:0] s3,
                           input logic [3:0] vis, input logic [3:0] dpLit);
    logic [6:0] glyph [4];
    logic [1:0] d;
    glyph = '{s0, s1, s2, s3};
    for (int i = 0; i < len; i++) begin
      d = 2'(((k0 + i) / 4) % 4);
      if (vis[d]) pushOne(toB, k0 + i, ~(4'b0001 << d), glyph[d], ~dpLit[d]);
      else        pushOne(toB, k0 + i, 4'b1111, GOFF, 1'b1);
    end
  endtask

  task automatic waitK(input int target);
    int n;
    n = 0;
    while (kCnt != target && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) begin
      nChecks++;
      nFail++;
      $display("[TB] FAIL wait_k: cycle index %0d, required %0d", kCnt, target);
    end
  endtask

  // Present a one-cycle load strobe that the DUT samples at cycle kAt
  task automatic applyStimulus(input int kAt, input logic [15:0] val, input logic [3:0] dpv);
    waitK(kAt - 1);
    bcd_in = val;
    dp_in  = dpv;
    load   = 1'b1;
    @(negedge clk);
    load   = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, cycle index %0d", kCnt);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1; bcd_in = 16'h0000; load = 1'b0; dp_in = 4'b0000; blank = 1'b0;
    pushOne(1'b0, -1, 4'b1111, GOFF, 1'b1);
    pushOne(1'b1, -1, 4'b1111, GOFF, 1'b1);
    repeat (3) @(negedge clk);

    // Idle after reset: only digit 0 lit with "0"; frame 2 precedes the first commit
    pushFrame(1'b0, 0, 48, G0, G0, G0, G0, 4'b0001, 4'b0000);
    rst = 1'b0;

    applyStimulus(33, 16'h1234, 4'b0000);
    pushFrame(1'b0, 48, 16, G4, G3, G2, G1, 4'b1111, 4'b0000);

    // 0070 with ones-digit dp; LZ_BLANK=0 instance shows every digit
    applyStimulus(50, 16'h0070, 4'b0001);
    pushFrame(1'b0, 64, 16, G0, G7, G0, G0, 4'b0011, 4'b0001);
    pushFrame(1'b1, 64, 16, G0, G7, G0, G0, 4'b1111, 4'b0001);

    // Two loads in one frame: last wins
    applyStimulus(66, 16'h5555, 4'b0000);
    applyStimulus(70, 16'h9999, 4'b0000);
    pushFrame(1'b0, 80, 16, G9, G9, G9, G9, 4'b1111, 4'b0000);

    // Load on frame_end: older pending commits first, new one a frame later
    applyStimulus(85, 16'h5555, 4'b0000);
    applyStimulus(95, 16'h00A3, 4'b0000);
    pushFrame(1'b0, 96, 16, G5, G5, G5, G5, 4'b1111, 4'b0000);
    pushFrame(1'b0, 112, 16, G3, GDASH, G0, G0, 4'b0011, 4'b0000);

    // 1234 with dp on digit 3, then blank for cycles 133..142
    applyStimulus(113, 16'h1234, 4'b1000);
    pushFrame(1'b0, 128, 5, G4, G3, G2, G1, 4'b1111, 4'b1000);
    for (int k = 133; k <= 142; k++) pushOne(1'b0, k, 4'b1111, GOFF, 1'b1);
    pushFrame(1'b0, 143, 1, G4, G3, G2, G1, 4'b1111, 4'b1000);
    pushFrame(1'b0, 144, 9, G4, G3, G2, G1, 4'b1111, 4'b1000);
    waitK(132);
    blank = 1'b1;
    repeat (10) @(negedge clk);
    blank = 1'b0;

    // Reset while 8888 is pending: it must never appear
    applyStimulus(150, 16'h8888, 4'b1111);
    waitK(152);
    pushOne(1'b0, -1, 4'b1111, GOFF, 1'b1);
    pushOne(1'b1, -1, 4'b1111, GOFF, 1'b1);
    pushFrame(1'b0, 0, 32, G0, G0, G0, G0, 4'b0001, 4'b0000);
    pushFrame(1'b1, 0, 16, G0, G0, G0, G0, 4'b1111, 4'b0000);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    waitK(33);

    nChecks++;
    if (qA.size() != 0) begin
      nFail++;
      $display("[TB] FAIL drain_lz_on: %0d expectations left, required 0", qA.size());
    end
    nChecks++;
    if (qB.size() != 0) begin
      nFail++;
      $display("[TB] FAIL drain_lz_off: %0d expectations left, required 0", qB.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
